// File: rtl/byte_assembly_reg_bank_if.sv
// Bus interface for byte_assembly_reg_bank: byte write port, sequential-assembly control and read port.
// The master drives writes and read selects; the slave returns read data and sequencer status.
interface byte_assembly_reg_bank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 4
);
  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned AW    = $clog2(NUM_REGS);
  localparam int unsigned LW    = $clog2(LANES);

  logic                  we;
  logic                  seq_mode;
  logic [AW-1:0]         wr_addr;
  logic [LW-1:0]         byte_sel;
  logic [7:0]            byte_in;
  logic                  seq_abort;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  word_done;
  logic                  seq_busy;

  modport master (
    output we, seq_mode, wr_addr, byte_sel, byte_in, seq_abort, rd_addr,
    input  rd_data, word_done, seq_busy
  );

  modport slave (
    input  we, seq_mode, wr_addr, byte_sel, byte_in, seq_abort, rd_addr,
    output rd_data, word_done, seq_busy
  );
endinterface

// File: rtl/byte_assembly_reg_bank.sv
// Register bank written a byte at a time, either to a chosen lane or by assembling a full word in order.
// Optional macro BYTE_ASM_MSB_FIRST_EN: sequential fill runs from the top lane down to lane 0.
module byte_assembly_reg_bank #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            NUM_REGS   = 4,
  parameter logic [DATA_WIDTH-1:0]  INIT       = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  byte_assembly_reg_bank_if.slave bus
);
  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned AW    = $clog2(NUM_REGS);
  localparam int unsigned LW    = $clog2(LANES);

`ifdef BYTE_ASM_MSB_FIRST_EN
  localparam logic [LW-1:0] FIRST_LANE = LW'(LANES - 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(0);

  function automatic logic [LW-1:0] step_lane(input logic [LW-1:0] p);
    return p - LW'(1);
  endfunction
`else
  localparam logic [LW-1:0] FIRST_LANE = LW'(0);
  localparam logic [LW-1:0] LAST_LANE  = LW'(LANES - 1);

  function automatic logic [LW-1:0] step_lane(input logic [LW-1:0] p);
    return p + LW'(1);
  endfunction
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_stage;
  logic [DATA_WIDTH-1:0] w_stage_nxt;
  logic [LW-1:0]         r_ptr;
  logic [LW-1:0]         w_ptr_nxt;
  logic [LW-1:0]         w_lane;
  logic [AW-1:0]         r_addr;
  logic [AW-1:0]         w_addr_nxt;
  logic                  r_word_done;
  logic                  w_commit;
  logic                  w_direct_we;
  logic                  w_stage_we;

  // Sequencer next state; abort wins over any write in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_addr_nxt  = r_addr;
    w_stage_nxt = r_stage;
    w_lane      = r_ptr;
    w_commit    = 1'b0;
    w_direct_we = 1'b0;
    w_stage_we  = 1'b0;

    if (bus.seq_abort) begin
      w_state_nxt = S_IDLE;
      w_ptr_nxt   = '0;
    end else if (bus.we) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.seq_mode) begin
            w_lane      = FIRST_LANE;
            w_stage_we  = 1'b1;
            w_addr_nxt  = bus.wr_addr;
            w_ptr_nxt   = step_lane(FIRST_LANE);
            w_state_nxt = S_FILL;
          end else begin
            w_direct_we = 1'b1;
          end
        end
        S_FILL: begin
          w_stage_we = 1'b1;
          if (r_ptr == LAST_LANE) begin
            w_commit    = 1'b1;
            w_ptr_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_ptr_nxt = step_lane(r_ptr);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    if (w_stage_we) begin
      w_stage_nxt[32'(w_lane)*8 +: 8] = bus.byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_stage     <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_addr      <= w_addr_nxt;
      r_stage     <= w_stage_nxt;
      r_word_done <= w_commit;
    end
  end

  // Register array: whole-word commit from staging, or a single-lane direct write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= INIT;
      end
    end else if (w_commit) begin
      r_regs[r_addr] <= w_stage_nxt;
    end else if (w_direct_we && (32'(bus.wr_addr) < NUM_REGS) && (32'(bus.byte_sel) < LANES)) begin
      r_regs[bus.wr_addr][32'(bus.byte_sel)*8 +: 8] <= bus.byte_in;
    end
  end

  assign bus.rd_data   = (32'(bus.rd_addr) < NUM_REGS) ? r_regs[bus.rd_addr] : '0;
  assign bus.word_done = r_word_done;
  assign bus.seq_busy  = (r_state == S_FILL);

endmodule

// File: tb/tb_byte_assembly_reg_bank.sv
// Self-checking bench for byte_assembly_reg_bank: directed vector table, reset corner cases and
// randomized traffic compared against a queue-based word-assembly model.
module tb_byte_assembly_reg_bank;
  localparam int unsigned DW    = 32;
  localparam int unsigned NR    = 4;
  localparam int unsigned LANES = DW / 8;
  localparam logic [DW-1:0] INIT_V = 32'hA5A5A5A5;
`ifdef BYTE_ASM_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_assembly_reg_bank_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

  byte_assembly_reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .INIT(INIT_V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: registers plus a queue of bytes collected for the pending word.
  logic [DW-1:0] m_reg [NR];
  logic [7:0]    m_q [$];
  logic [1:0]    m_addr;
  logic          m_done;

  typedef struct {
    logic          we;
    logic          seq;
    logic [1:0]    addr;
    logic [1:0]    sel;
    logic [7:0]    b;
    logic          ab;
    logic [1:0]    rd;
    logic [DW-1:0] exp_rd;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vt [20];

  function automatic logic [DW-1:0] pick(input logic [DW-1:0] lsb_val, input logic [DW-1:0] msb_val);
    return MSB ? msb_val : lsb_val;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = INIT_V;
    m_q.delete();
    m_done = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic seq, input logic [1:0] addr,
                            input logic [1:0] sel, input logic [7:0] b, input logic ab);
    logic [DW-1:0] word;
    m_done = 1'b0;
    if (ab) begin
      m_q.delete();
    end else if (we) begin
      if (m_q.size() == 0 && !seq) begin
        m_reg[addr][32'(sel)*8 +: 8] = b;
      end else begin
        if (m_q.size() == 0) m_addr = addr;
        m_q.push_back(b);
        if (m_q.size() == LANES) begin
          word = '0;
          for (int i = 0; i < LANES; i++) begin
            if (MSB) word[(LANES-1-i)*8 +: 8] = m_q[i];
            else     word[i*8 +: 8] = m_q[i];
          end
          m_reg[m_addr] = word;
          m_q.delete();
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic apply(input logic we, input logic seq, input logic [1:0] addr,
                       input logic [1:0] sel, input logic [7:0] b, input logic ab,
                       input logic [1:0] rd);
    bus.we        = we;
    bus.seq_mode  = seq;
    bus.wr_addr   = addr;
    bus.byte_sel  = sel;
    bus.byte_in   = b;
    bus.seq_abort = ab;
    bus.rd_addr   = rd;
    @(posedge clk);
    model_edge(we, seq, addr, sel, b, ab);
    #1;
    bus.we        = 1'b0;
    bus.seq_abort = 1'b0;
  endtask

  task automatic scan(input string name);
    for (int r = 0; r < NR; r++) begin
      bus.rd_addr = 2'(r);
      #1;
      chk(name, bus.rd_data, m_reg[r]);
    end
  endtask

  initial begin
    bus.we = 1'b0; bus.seq_mode = 1'b0; bus.wr_addr = '0; bus.byte_sel = '0;
    bus.byte_in = '0; bus.seq_abort = 1'b0; bus.rd_addr = '0;
    model_reset();

    vt[0]  = '{1'b1, 1'b0, 2'd2, 2'd1, 8'h3C, 1'b0, 2'd2, 32'hA5A53CA5, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd0, INIT_V,       1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 2'd1, 2'd0, 8'h11, 1'b0, 2'd1, INIT_V,       1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 2'd3, 2'd2, 8'h22, 1'b0, 2'd3, INIT_V,       1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 2'd0, 2'd3, 8'h33, 1'b0, 2'd1, INIT_V,       1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 2'd2, 2'd0, 8'h44, 1'b0, 2'd1, pick(32'h44332211, 32'h11223344), 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 2'd1, pick(32'h44332211, 32'h11223344), 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 2'd3, 2'd0, 8'h01, 1'b0, 2'd3, INIT_V,       1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 2'd3, 2'd0, 8'h00, 1'b0, 2'd3, INIT_V,       1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 2'd3, 2'd0, 8'h02, 1'b0, 2'd3, INIT_V,       1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b1, 2'd3, 2'd0, 8'h03, 1'b1, 2'd3, INIT_V,       1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 2'd3, 2'd0, 8'hAA, 1'b0, 2'd3, INIT_V,       1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b1, 2'd3, 2'd0, 8'hBB, 1'b0, 2'd3, INIT_V,       1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b1, 2'd3, 2'd0, 8'hCC, 1'b0, 2'd3, INIT_V,       1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b1, 2'd3, 2'd0, 8'hDD, 1'b0, 2'd3, pick(32'hDDCCBBAA, 32'hAABBCCDD), 1'b0, 1'b1};
    vt[15] = '{1'b1, 1'b1, 2'd0, 2'd0, 8'h01, 1'b0, 2'd0, INIT_V,       1'b1, 1'b0};
    vt[16] = '{1'b1, 1'b1, 2'd0, 2'd0, 8'h02, 1'b0, 2'd0, INIT_V,       1'b1, 1'b0};
    vt[17] = '{1'b1, 1'b1, 2'd0, 2'd0, 8'h03, 1'b0, 2'd0, INIT_V,       1'b1, 1'b0};
    vt[18] = '{1'b1, 1'b1, 2'd0, 2'd0, 8'h04, 1'b0, 2'd0, pick(32'h04030201, 32'h01020304), 1'b0, 1'b1};
    vt[19] = '{1'b1, 1'b0, 2'd2, 2'd0, 8'h5A, 1'b0, 2'd2, 32'hA5A53C5A, 1'b0, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.seq_busy), 32'd0);
    chk("rst_done", 32'(bus.word_done), 32'd0);
    for (int r = 0; r < NR; r++) begin
      bus.rd_addr = 2'(r);
      #1;
      chk("rst_rd", bus.rd_data, INIT_V);
    end

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      apply(vt[i].we, vt[i].seq, vt[i].addr, vt[i].sel, vt[i].b, vt[i].ab, vt[i].rd);
      chk($sformatf("vec%0d_rd", i),   bus.rd_data, vt[i].exp_rd);
      chk($sformatf("vec%0d_busy", i), 32'(bus.seq_busy), 32'(vt[i].exp_busy));
      chk($sformatf("vec%0d_done", i), 32'(bus.word_done), 32'(vt[i].exp_done));
    end
    scan("table_scan");

    // Reset asserted mid-fill discards the partial word
    apply(1'b1, 1'b1, 2'd2, 2'd0, 8'h77, 1'b0, 2'd2);
    apply(1'b1, 1'b1, 2'd2, 2'd0, 8'h88, 1'b0, 2'd2);
    chk("midrst_busy_pre", 32'(bus.seq_busy), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_busy", 32'(bus.seq_busy), 32'd0);
    chk("midrst_done", 32'(bus.word_done), 32'd0);
    scan("midrst_regs");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 2'd3, 2'd3, 8'h00, 1'b1, 2'd2);
      chk("postrst_done", 32'(bus.word_done), 32'd0);
      chk("postrst_busy", 32'(bus.seq_busy), 32'd0);
    end
    scan("postrst_regs");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic we, seq, ab;
      logic [1:0] addr, sel, rd;
      logic [7:0] b;
      we   = ($urandom_range(0, 3) != 0);
      seq  = ($urandom_range(0, 3) != 0);
      ab   = ($urandom_range(0, 15) == 0);
      addr = 2'($urandom_range(0, 3));
      sel  = 2'($urandom_range(0, 3));
      rd   = 2'($urandom_range(0, 3));
      b    = 8'($urandom_range(0, 255));
      apply(we, seq, addr, sel, b, ab, rd);
      chk("rand_rd",   bus.rd_data, m_reg[rd]);
      chk("rand_busy", 32'(bus.seq_busy), 32'(m_q.size() != 0));
      chk("rand_done", 32'(bus.word_done), 32'(m_done));
      if (i % 50 == 49) scan("rand_scan");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_assembly_reg_bank.md
BYTE_ASSEMBLY_REG_BANK -- requirements
Module: byte_assembly_reg_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register width in bits; SHALL be a multiple of 8 and at least 16; LANES = DATA_WIDTH/8.
REQ-002 Parameter NUM_REGS, default 4: number of registers; SHALL be at least 2; AW = $clog2(NUM_REGS), LW = $clog2(LANES).
REQ-003 Parameter INIT, default 0: reset value of every register.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port we, input, 1: byte write strobe.
REQ-007 Port seq_mode, input, 1: 0 = direct lane write, 1 = sequential assembly.
REQ-008 Port wr_addr, input, AW: target register.
REQ-009 Port byte_sel, input, LW: target lane in direct mode; ignored in sequential mode.
REQ-010 Port byte_in, input, 8: write data.
REQ-011 Port seq_abort, input, 1: discards a partial sequential word.
REQ-012 Port rd_addr, input, AW: read select.
REQ-013 Port rd_data, output, DATA_WIDTH: combinational read of register rd_addr.
REQ-014 Port word_done, output, 1: one-cycle pulse on sequential commit.
REQ-015 Port seq_busy, output, 1: high while a sequential word is partially assembled.

Function
REQ-016 Direct mode: with we=1 and seq_mode=0, register wr_addr lane byte_sel SHALL take byte_in on the next edge; other lanes and registers SHALL be unchanged.
REQ-017 Sequential FSM states: IDLE and FILL.
REQ-018 In IDLE, we=1 and seq_mode=1 SHALL: latch wr_addr, write byte_in into staging lane 0, set lane pointer to 1, and go to FILL.
REQ-019 In FILL, each we=1 SHALL write byte_in into staging lane ptr and increment ptr; wr_addr, seq_mode, and byte_sel are ignored.
REQ-020 When the byte written has ptr = LANES-1, the edge SHALL copy the full staging word into the latched register atomically, pulse word_done high for the following cycle, and return to IDLE.
REQ-021 The target register SHALL NOT change before commit; rd_data for that register shows the old value until the commit edge.
REQ-022 seq_busy SHALL equal (state == FILL).
REQ-023 seq_abort=1 SHALL return the FSM to IDLE, clear ptr, and leave all registers unchanged; seq_abort takes priority over a simultaneous we.
REQ-024 A direct write (seq_mode=0) during FILL SHALL be ignored, and the sequence SHALL continue; seq_mode is sampled only in IDLE.
REQ-025 we=0 cycles inside FILL SHALL hold state; there is no timeout.
REQ-026 Back-to-back sequential words with no gap SHALL be accepted: the IDLE entry on the cycle after commit takes a new byte.
REQ-027 word_done SHALL be registered and never high for two consecutive cycles from one commit.

Reset
REQ-028 rst_n=0 SHALL immediately force:
- all registers to INIT;
- staging buffer to 0;
- ptr to 0;
- state to IDLE;
- word_done and seq_busy to 0.
REQ-029 Reset asserted mid-sequence SHALL discard the partial word with no commit.

Configuration
REQ-030 Macro BYTE_ASM_MSB_FIRST_EN: when defined, sequential fill SHALL start at lane LANES-1 and decrement, with commit after lane 0.
REQ-031 When BYTE_ASM_MSB_FIRST_EN is undefined, fill order SHALL be LSB-first, as in REQ-018 to REQ-020; direct mode is unaffected in both cases.

Verification
REQ-032 Reset: release rst_n with INIT=0xA5A5A5A5 -> rd_data = 0xA5A5A5A5 for rd_addr 0..3; word_done=0; seq_busy=0.
REQ-033 Direct write: we, addr 2, byte_sel 1, byte 0x3C -> reg2 = 0xA5A53CA5; others unchanged.
REQ-034 Sequential write: addr 1, bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> reg1 stays 0xA5A5A5A5 through the third byte, becomes 0x44332211 at the fourth edge, and word_done pulses once.
REQ-035 Abort: sequential bytes 0x01, 0x02 to addr 3, then seq_abort together with we -> reg3 unchanged, seq_busy=0; the next sequential byte starts at lane 0.
REQ-036 Reset mid-fill: after two sequential bytes, pulse rst_n low -> all registers = INIT, no word_done.
REQ-037 MSB-first build with BYTE_ASM_MSB_FIRST_EN: bytes 0x11, 0x22, 0x33, 0x44 -> register = 0x11223344.
